// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the pipe_ctrl control unit.
// The datapath side (master) drives the ID-stage fields and ex_zero; pipe_ctrl (slave) returns the per-stage controls.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             ex_zero;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             ex_RegDst;
    logic             ex_AluSrc;
    logic [3:0]       ex_ALUOp;
    logic             branch_taken;
    logic             mem_MemRead;
    logic             mem_MemWrite;
    logic             wb_RegWrite;
    logic             wb_MemtoReg;
    logic [4:0]       wb_waddr;
    logic             illegal_op;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  id_opcode, id_rs, id_rt, id_rd, ex_zero,
        output pc_write, ifid_write, ifid_flush, ex_RegDst, ex_AluSrc, ex_ALUOp,
               branch_taken, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg,
               wb_waddr, illegal_op, stall_cnt, flush_cnt
    );

    modport master (
        output id_opcode, id_rs, id_rt, id_rd, ex_zero,
        input  pc_write, ifid_write, ifid_flush, ex_RegDst, ex_AluSrc, ex_ALUOp,
               branch_taken, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg,
               wb_waddr, illegal_op, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Control unit for a 5-stage MIPS pipeline: ID decode, per-stage control registers,
// load-use stall and taken-branch flush detection, saturating stall/flush counters.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave bus
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // Each stage register only keeps the fields still needed downstream.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] waddr;
    } idex_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] waddr;
    } exmem_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] waddr;
    } memwb_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    idex_t            dec_s;
    logic             illegal_s;
    logic             uses_rt_s;
    logic             load_use_s;
    logic             branch_taken_s;
    logic             stall_s;
    logic             bubble_s;
    idex_t            idex_r;
    exmem_t           exmem_r;
    memwb_t           memwb_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // ID-stage opcode decode into the control bundle plus destination register
    always_comb begin
        dec_s     = '0;
        illegal_s = 1'b0;
        uses_rt_s = 1'b0;
        case (bus.id_opcode)
            OP_R: begin
                dec_s.reg_dst   = 1'b1;
                dec_s.alu_op    = 4'b0010;
                dec_s.reg_write = 1'b1;
                uses_rt_s       = 1'b1;
            end
            OP_LW: begin
                dec_s.alu_src    = 1'b1;
                dec_s.mem_read   = 1'b1;
                dec_s.mem_to_reg = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.alu_op     = 4'b0000;
            end
            OP_SW: begin
                dec_s.alu_src   = 1'b1;
                dec_s.mem_write = 1'b1;
                dec_s.alu_op    = 4'b0000;
                uses_rt_s       = 1'b1;
            end
            OP_BEQ: begin
                dec_s.branch = 1'b1;
                dec_s.alu_op = 4'b0001;
                uses_rt_s    = 1'b1;
            end
            OP_ADDI: begin
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.alu_op    = 4'b0000;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        // An unknown opcode travels as a pure NOP, destination included.
        if (illegal_s) begin
            dec_s.waddr = 5'd0;
        end else begin
            dec_s.waddr = dec_s.reg_dst ? bus.id_rd : bus.id_rt;
        end
    end

    assign load_use_s = idex_r.mem_read && (idex_r.waddr != 5'd0) &&
                        ((idex_r.waddr == bus.id_rs) ||
                         ((idex_r.waddr == bus.id_rt) && uses_rt_s));
    assign branch_taken_s = idex_r.branch & bus.ex_zero;
    // A taken branch discards the dependent instruction anyway, so it overrides the stall.
    assign stall_s  = load_use_s & ~branch_taken_s;
    assign bubble_s = stall_s | branch_taken_s;

    // Control bundle advances one stage per clock; a bubble replaces the ID entry on stall/flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_r  <= '0;
            exmem_r <= '0;
            memwb_r <= '0;
        end else begin
            idex_r  <= bubble_s ? idex_t'('0) : dec_s;
            exmem_r <= '{mem_read:   idex_r.mem_read,
                         mem_write:  idex_r.mem_write,
                         reg_write:  idex_r.reg_write,
                         mem_to_reg: idex_r.mem_to_reg,
                         waddr:      idex_r.waddr};
            memwb_r <= '{reg_write:  exmem_r.reg_write,
                         mem_to_reg: exmem_r.mem_to_reg,
                         waddr:      exmem_r.waddr};
        end
    end

    // Saturating performance counters for stall cycles and taken-branch flushes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (branch_taken_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign bus.pc_write     = ~stall_s;
    assign bus.ifid_write   = ~stall_s;
    assign bus.ifid_flush   = branch_taken_s;
    assign bus.branch_taken = branch_taken_s;
    assign bus.illegal_op   = illegal_s;
    assign bus.ex_RegDst    = idex_r.reg_dst;
    assign bus.ex_AluSrc    = idex_r.alu_src;
    assign bus.ex_ALUOp     = idex_r.alu_op;
    assign bus.mem_MemRead  = exmem_r.mem_read;
    assign bus.mem_MemWrite = exmem_r.mem_write;
    // Writes to $zero are suppressed at the register-file port.
    assign bus.wb_RegWrite  = memwb_r.reg_write & (memwb_r.waddr != 5'd0);
    assign bus.wb_MemtoReg  = memwb_r.mem_to_reg;
    assign bus.wb_waddr     = memwb_r.waddr;
    assign bus.stall_cnt    = stall_cnt_r;
    assign bus.flush_cnt    = flush_cnt_r;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues expected values, a negedge monitor compares them.
// A second instance with a 2-bit counter width exercises counter saturation.
module tb_pipe_ctrl;
    logic clk;
    logic reset;

    pipe_ctrl_if #(.CNT_W(16)) bus ();
    pipe_ctrl_if #(.CNT_W(2))  bus_s ();

    pipe_ctrl #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(bus));
    pipe_ctrl #(.CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    localparam int S_PCW = 0, S_IFW = 1, S_FLU = 2, S_RDST = 3, S_ASRC = 4, S_ALUOP = 5,
                   S_BT = 6, S_MRD = 7, S_MWR = 8, S_RW = 9, S_M2R = 10, S_WA = 11,
                   S_ILL = 12, S_SCNT = 13, S_FCNT = 14, S_SCNT2 = 15;

    localparam logic [5:0] R = 6'h00, BEQ = 6'h04, ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BAD = 6'h3F;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_PCW:   return {31'd0, bus.pc_write};
            S_IFW:   return {31'd0, bus.ifid_write};
            S_FLU:   return {31'd0, bus.ifid_flush};
            S_RDST:  return {31'd0, bus.ex_RegDst};
            S_ASRC:  return {31'd0, bus.ex_AluSrc};
            S_ALUOP: return {28'd0, bus.ex_ALUOp};
            S_BT:    return {31'd0, bus.branch_taken};
            S_MRD:   return {31'd0, bus.mem_MemRead};
            S_MWR:   return {31'd0, bus.mem_MemWrite};
            S_RW:    return {31'd0, bus.wb_RegWrite};
            S_M2R:   return {31'd0, bus.wb_MemtoReg};
            S_WA:    return {27'd0, bus.wb_waddr};
            S_ILL:   return {31'd0, bus.illegal_op};
            S_SCNT:  return {16'd0, bus.stall_cnt};
            S_FCNT:  return {16'd0, bus.flush_cnt};
            S_SCNT2: return {30'd0, bus_s.stall_cnt};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: outputs are settled half a cycle after the active edge
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks = checks + 1;
            if (observe(mon_e.sel) !== mon_e.val) begin
                failures = failures + 1;
                $display("FAIL %s: got %0h expected %0h at %0t", mon_e.name,
                         observe(mon_e.sel), mon_e.val, $time);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] val, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic z);
        bus.id_opcode   = op;  bus.id_rs   = rs;  bus.id_rt   = rt;  bus.id_rd   = rd;  bus.ex_zero   = z;
        bus_s.id_opcode = op;  bus_s.id_rs = rs;  bus_s.id_rt = rt;  bus_s.id_rd = rd;  bus_s.ex_zero = z;
    endtask

    task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic z);
        @(posedge clk);
        #1;
        drive(op, rs, rt, rd, z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(LW, 5'd1, 5'd8, 5'd0, 1'b0);

        // Reset state
        step(LW, 5'd1, 5'd8, 5'd0, 1'b0);
        expect_val(S_PCW, 32'd1, "rst_pc_write");
        expect_val(S_IFW, 32'd1, "rst_ifid_write");
        expect_val(S_FLU, 32'd0, "rst_ifid_flush");
        expect_val(S_ASRC, 32'd0, "rst_ex_alusrc");
        expect_val(S_BT, 32'd0, "rst_branch_taken");
        expect_val(S_SCNT, 32'd0, "rst_stall_cnt");
        expect_val(S_FCNT, 32'd0, "rst_flush_cnt");
        @(negedge clk); #1;
        reset = 1'b0;

        // 1: lw enters EX, dependent add in ID, then asynchronous reset mid-cycle
        step(R, 5'd8, 5'd9, 5'd10, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        checks = checks + 1;
        if ((bus.ex_AluSrc !== 1'b0) || (bus.mem_MemRead !== 1'b0)) begin
            failures = failures + 1;
            $display("FAIL t1_immediate_ex_mem: got %0b/%0b expected 0/0 at %0t",
                     bus.ex_AluSrc, bus.mem_MemRead, $time);
        end
        checks = checks + 1;
        if (bus.pc_write !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL t1_immediate_pc_write: got %0b expected 1 at %0t", bus.pc_write, $time);
        end
        checks = checks + 1;
        if (bus.stall_cnt !== 16'd0) begin
            failures = failures + 1;
            $display("FAIL t1_immediate_stall_cnt: got %0h expected 0 at %0t", bus.stall_cnt, $time);
        end
        expect_val(S_ASRC, 32'd0, "t1_async_ex_alusrc");
        expect_val(S_ALUOP, 32'd0, "t1_async_ex_aluop");
        expect_val(S_MRD, 32'd0, "t1_async_mem_read");
        expect_val(S_WA, 32'd0, "t1_async_wb_waddr");
        expect_val(S_PCW, 32'd1, "t1_async_pc_write");
        expect_val(S_SCNT, 32'd0, "t1_async_stall_cnt");
        @(negedge clk); #1;
        reset = 1'b0;

        // 2: load-use stall
        step(LW, 5'd1, 5'd8, 5'd0, 1'b0);
        expect_val(S_RDST, 32'd1, "t2_postrst_add_regdst");
        expect_val(S_ALUOP, 32'd2, "t2_postrst_add_aluop");
        step(R, 5'd8, 5'd9, 5'd10, 1'b0);
        expect_val(S_ASRC, 32'd1, "t2_lw_ex_alusrc");
        expect_val(S_PCW, 32'd0, "t2_stall_pc_write");
        expect_val(S_IFW, 32'd0, "t2_stall_ifid_write");
        expect_val(S_SCNT, 32'd0, "t2_stall_cnt_before");
        step(R, 5'd8, 5'd9, 5'd10, 1'b0);
        expect_val(S_RDST, 32'd0, "t2_bubble_regdst");
        expect_val(S_ALUOP, 32'd0, "t2_bubble_aluop");
        expect_val(S_ASRC, 32'd0, "t2_bubble_alusrc");
        expect_val(S_PCW, 32'd1, "t2_release_pc_write");
        expect_val(S_SCNT, 32'd1, "t2_stall_cnt_after");
        expect_val(S_MRD, 32'd1, "t2_lw_mem_read");
        expect_val(S_WA, 32'd10, "t2_add_wb_waddr");
        step(R, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_val(S_RDST, 32'd1, "t2_add_ex_regdst");
        expect_val(S_ALUOP, 32'd2, "t2_add_ex_aluop");
        expect_val(S_RW, 32'd1, "t2_lw_wb_regwrite");
        expect_val(S_WA, 32'd8, "t2_lw_wb_waddr");
        expect_val(S_M2R, 32'd1, "t2_lw_wb_memtoreg");

        // 3: lw to $zero never stalls and never writes
        step(LW, 5'd1, 5'd0, 5'd0, 1'b0);
        expect_val(S_RW, 32'd0, "t3_bubble_wb_regwrite");
        step(R, 5'd0, 5'd0, 5'd11, 1'b0);
        expect_val(S_PCW, 32'd1, "t3_no_stall_pc_write");
        expect_val(S_RW, 32'd1, "t3_add_wb_regwrite");
        expect_val(S_WA, 32'd10, "t3_add_wb_waddr");
        step(R, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_val(S_SCNT, 32'd1, "t3_stall_cnt_same");
        step(R, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_val(S_RW, 32'd0, "t3_lw0_wb_regwrite");
        expect_val(S_M2R, 32'd1, "t3_lw0_wb_memtoreg");
        expect_val(S_WA, 32'd0, "t3_lw0_wb_waddr");

        // 4: beq taken, then beq not taken
        step(BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        step(ADDI, 5'd3, 5'd4, 5'd0, 1'b1);
        expect_val(S_BT, 32'd1, "t4_branch_taken");
        expect_val(S_FLU, 32'd1, "t4_ifid_flush");
        expect_val(S_PCW, 32'd1, "t4_flush_pc_write");
        expect_val(S_ALUOP, 32'd1, "t4_beq_aluop");
        step(ADDI, 5'd3, 5'd4, 5'd0, 1'b0);
        expect_val(S_ALUOP, 32'd0, "t4_flushed_aluop");
        expect_val(S_ASRC, 32'd0, "t4_flushed_alusrc");
        expect_val(S_FLU, 32'd0, "t4_flush_cleared");
        expect_val(S_FCNT, 32'd1, "t4_flush_cnt");
        step(BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        expect_val(S_ASRC, 32'd1, "t4_addi_alusrc");
        step(R, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_val(S_BT, 32'd0, "t4_not_taken");
        expect_val(S_FLU, 32'd0, "t4_not_taken_flush");
        step(R, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_val(S_ALUOP, 32'd2, "t4_no_penalty_aluop");
        expect_val(S_FCNT, 32'd1, "t4_flush_cnt_same");

        // 5: taken branch in EX with a lw-dependent add in ID
        step(LW, 5'd1, 5'd12, 5'd0, 1'b0);
        step(BEQ, 5'd5, 5'd6, 5'd0, 1'b0);
        expect_val(S_PCW, 32'd1, "t5_beq_no_stall");
        step(R, 5'd12, 5'd12, 5'd13, 1'b1);
        expect_val(S_BT, 32'd1, "t5_branch_taken");
        expect_val(S_PCW, 32'd1, "t5_pc_write");
        expect_val(S_IFW, 32'd1, "t5_ifid_write");
        step(R, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_val(S_ALUOP, 32'd0, "t5_flushed_aluop");
        expect_val(S_FCNT, 32'd2, "t5_flush_cnt");
        expect_val(S_SCNT, 32'd1, "t5_stall_cnt_same");

        // 6: counter saturation on the 2-bit instance, then illegal opcode
        @(posedge clk); #1;
        reset = 1'b1;
        drive(R, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_val(S_SCNT, 32'd0, "t6_rst_stall_cnt");
        expect_val(S_SCNT2, 32'd0, "t6_rst_stall_cnt2");
        @(negedge clk); #1;
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step(LW, 5'd1, 5'd8, 5'd0, 1'b0);
            step(R, 5'd8, 5'd9, 5'd10, 1'b0);
            expect_val(S_PCW, 32'd0, $sformatf("t6_stall%0d_pc_write", k));
            step(R, 5'd8, 5'd9, 5'd10, 1'b0);
            expect_val(S_SCNT, 32'(k), $sformatf("t6_stall%0d_cnt", k));
            expect_val(S_SCNT2, (k > 3) ? 32'd3 : 32'(k), $sformatf("t6_stall%0d_cnt2", k));
        end
        step(BAD, 5'd1, 5'd2, 5'd3, 1'b0);
        expect_val(S_ILL, 32'd1, "t6_illegal_op");
        step(SW, 5'd1, 5'd2, 5'd0, 1'b0);
        expect_val(S_ILL, 32'd0, "t6_sw_legal");
        expect_val(S_RDST, 32'd0, "t6_nop_regdst");
        expect_val(S_ASRC, 32'd0, "t6_nop_alusrc");
        expect_val(S_ALUOP, 32'd0, "t6_nop_aluop");
        step(R, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_val(S_ASRC, 32'd1, "t6_sw_alusrc");
        expect_val(S_MRD, 32'd0, "t6_nop_mem_read");
        expect_val(S_MWR, 32'd0, "t6_nop_mem_write");
        step(R, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_val(S_MWR, 32'd1, "t6_sw_mem_write");
        expect_val(S_RW, 32'd0, "t6_nop_wb_regwrite");
        expect_val(S_WA, 32'd0, "t6_nop_wb_waddr");
        expect_val(S_M2R, 32'd0, "t6_nop_wb_memtoreg");

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
